regfile_write_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback and a long-latency multi-cycle unit (mul/div). Multi-cycle results are buffered in a small FIFO. Pipeline writes have priority, but a starvation limit eventually forces a buffered result through by stalling the pipeline. A 32-bit busy scoreboard tracks registers with outstanding multi-cycle results so upstream hazard logic can stall dependent instructions.

---
 rtl/regfile_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// buffered multi-cycle results, and tracks registers that have results still outstanding.
module regfile_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_wr_enable,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_write_data,
  output logic            pipe_stall,
  input  logic            mc_issue_valid,
  input  logic [4:0]      mc_issue_rd,
  input  logic            mc_result_valid,
  input  logic [4:0]      mc_result_rd,
  input  logic [XLEN-1:0] mc_result_data,
  output logic            mc_result_ready,
  output logic            rf_wr_enable,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_write_data,
  output logic [31:0]     busy_mask
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      r_fifoRd   [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifoData [FIFO_DEPTH];
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starveCnt;

  logic            w_fifoReq;
  logic            w_full;
  logic            w_force;
  logic            w_grantPipe;
  logic            w_grantFifo;
  logic            w_push;
  logic            w_pop;
  logic [4:0]      w_headRd;
  logic [XLEN-1:0] w_headData;
  logic [31:0]     w_setMask;
  logic [31:0]     w_clearMask;

  assign w_fifoReq  = (r_count != '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_force    = w_fifoReq && (r_starveCnt == SW'(STARVE_LIMIT));
  assign w_headRd   = r_fifoRd[r_rdPtr];
  assign w_headData = r_fifoData[r_rdPtr];

  // Pipeline wins unless the buffered head has been passed over too long.
  always_comb begin
    w_grantPipe = 1'b0;
    w_grantFifo = 1'b0;
    if (wb_wr_enable && !w_force) begin
      w_grantPipe = 1'b1;
    end else if (w_fifoReq) begin
      w_grantFifo = 1'b1;
    end
  end

  assign w_push          = mc_result_valid && !w_full;
  assign w_pop           = w_grantFifo;
  assign mc_result_ready = !w_full;
  assign pipe_stall      = wb_wr_enable && w_grantFifo;

  always_comb begin
    w_setMask   = '0;
    w_clearMask = '0;
    if (mc_issue_valid && (mc_issue_rd != 5'd0)) begin
      w_setMask = 32'd1 << mc_issue_rd;
    end
    if (w_pop) begin
      w_clearMask = 32'd1 << w_headRd;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoRd[r_wrPtr]   <= mc_result_rd;
      r_fifoData[r_wrPtr] <= mc_result_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A non-empty FIFO that is not popped was necessarily passed over this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starveCnt <= '0;
    end else if (w_pop || !w_fifoReq) begin
      r_starveCnt <= '0;
    end else if (r_starveCnt != SW'(STARVE_LIMIT)) begin
      r_starveCnt <= r_starveCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_enable  <= 1'b0;
      rf_rd         <= '0;
      rf_write_data <= '0;
    end else if (w_grantPipe) begin
      rf_wr_enable  <= (wb_rd != 5'd0);
      rf_rd         <= wb_rd;
      rf_write_data <= wb_write_data;
    end else if (w_grantFifo) begin
      rf_wr_enable  <= (w_headRd != 5'd0);
      rf_rd         <= w_headRd;
      rf_write_data <= w_headData;
    end else begin
      rf_wr_enable  <= 1'b0;
    end
  end

  // A new issue to the same register outranks the retiring result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= (busy_mask & ~w_clearMask) | w_setMask;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a queue-based
// behavioural model of the write-port arbitration and busy scoreboard.
module tb_regfile_write_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wb_wr_enable = 1'b0;
  logic [4:0]      wb_rd = '0;
  logic [XLEN-1:0] wb_write_data = '0;
  logic            pipe_stall;
  logic            mc_issue_valid = 1'b0;
  logic [4:0]      mc_issue_rd = '0;
  logic            mc_result_valid = 1'b0;
  logic [4:0]      mc_result_rd = '0;
  logic [XLEN-1:0] mc_result_data = '0;
  logic            mc_result_ready;
  logic            rf_wr_enable;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_write_data;
  logic [31:0]     busy_mask;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_wr_enable(wb_wr_enable), .wb_rd(wb_rd), .wb_write_data(wb_write_data),
    .pipe_stall(pipe_stall),
    .mc_issue_valid(mc_issue_valid), .mc_issue_rd(mc_issue_rd),
    .mc_result_valid(mc_result_valid), .mc_result_rd(mc_result_rd),
    .mc_result_data(mc_result_data), .mc_result_ready(mc_result_ready),
    .rf_wr_enable(rf_wr_enable), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  int          starve;
  logic [31:0] mBusy;
  logic        mWe;
  logic [4:0]  mRd;
  logic [31:0] mData;
  logic        gPipe, gFifo, mStall, mReady;

  function automatic void modelReset();
    q.delete();
    starve = 0;
    mBusy  = '0;
    mWe    = 1'b0;
    mRd    = '0;
    mData  = '0;
    mStall = 1'b0;
    mReady = 1'b1;
  endfunction

  function automatic void evalComb();
    logic fifoReq;
    logic forced;
    fifoReq = (q.size() != 0);
    forced  = fifoReq && (starve == LIMIT);
    gPipe   = wb_wr_enable && !forced;
    gFifo   = !gPipe && fifoReq;
    mStall  = wb_wr_enable && gFifo;
    mReady  = (q.size() < DEPTH);
  endfunction

  function automatic void commitEdge();
    entry_t e;
    logic   wasEmpty;
    logic   pushOk;
    wasEmpty = (q.size() == 0);
    pushOk   = mc_result_valid && mReady;
    if (gPipe) begin
      mWe = (wb_rd != 0); mRd = wb_rd; mData = wb_write_data;
    end else if (gFifo) begin
      e = q.pop_front();
      mWe = (e.rd != 0); mRd = e.rd; mData = e.data;
      mBusy[e.rd] = 1'b0;
    end else begin
      mWe = 1'b0;
    end
    if (mc_issue_valid && mc_issue_rd != 0) mBusy[mc_issue_rd] = 1'b1;
    if (gFifo || wasEmpty) starve = 0;
    else if (starve < LIMIT) starve = starve + 1;
    if (pushOk) begin
      e.rd = mc_result_rd; e.data = mc_result_data;
      q.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    wb_wr_enable = 0; wb_rd = 0; wb_write_data = 0;
    mc_issue_valid = 0; mc_issue_rd = 0;
    mc_result_valid = 0; mc_result_rd = 0; mc_result_data = 0;
  endtask

  task automatic stepModel();
    #1;
    evalComb();
    commitEdge();
    tick();
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 0;
    #2;
    modelReset();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 0;
    mc_result_valid = 1; mc_result_rd = 5; mc_result_data = 32'hDEADBEEF;
    tick(); tick();
    checks++; if (rf_wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", rf_wr_enable); end
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("[TB] FAIL reset_busy got %h want 0", busy_mask); end
    checks++; if (mc_result_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", mc_result_ready); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", pipe_stall); end
    modelReset();
    rst_n = 1;
    stepModel();
    mc_result_valid = 0;
    checks++; if (rf_wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL first_push_nobypass got %b want 0", rf_wr_enable); end
    stepModel();
    checks++; if (rf_wr_enable !== 1'b1 || rf_rd !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL first_result got we=%b rd=%0d data=%h want we=1 rd=5 data=deadbeef", rf_wr_enable, rf_rd, rf_write_data);
    end
  endtask

  task automatic test_scoreboard();
    doReset();
    mc_issue_valid = 1; mc_issue_rd = 7;
    stepModel();
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("[TB] FAIL sb_set got %h want 00000080", busy_mask); end
    mc_issue_valid = 0;
    mc_result_valid = 1; mc_result_rd = 7; mc_result_data = 32'h1234_5678;
    stepModel();
    mc_result_valid = 0;
    checks++; if (rf_wr_enable !== 1'b0 || busy_mask !== 32'h80) begin
      errors++; $display("[TB] FAIL sb_pushed got we=%b busy=%h want we=0 busy=00000080", rf_wr_enable, busy_mask);
    end
    stepModel();
    checks++; if (rf_wr_enable !== 1'b1 || rf_rd !== 5'd7 || rf_write_data !== 32'h1234_5678 || busy_mask !== 32'h0) begin
      errors++; $display("[TB] FAIL sb_retire got we=%b rd=%0d data=%h busy=%h want we=1 rd=7 data=12345678 busy=0", rf_wr_enable, rf_rd, rf_write_data, busy_mask);
    end
    mc_issue_valid = 1; mc_issue_rd = 0;
    stepModel();
    mc_issue_valid = 0;
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("[TB] FAIL sb_x0_issue got %h want 0", busy_mask); end
  endtask

  task automatic test_priority();
    int stallCnt;
    int firstStall;
    doReset();
    stallCnt = 0; firstStall = -1;
    wb_wr_enable = 1; wb_rd = 3; wb_write_data = 100;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0 && !mStall) wb_write_data = 100 + cyc;
      mc_result_valid = (cyc == 0); mc_result_rd = 10; mc_result_data = 32'hA0A0;
      #1;
      evalComb();
      checks++; if (pipe_stall !== mStall) begin errors++; $display("[TB] FAIL prio_stall cyc %0d got %b want %b", cyc, pipe_stall, mStall); end
      if (pipe_stall === 1'b1) begin
        stallCnt++;
        if (firstStall < 0) firstStall = cyc;
      end
      commitEdge();
      tick();
      checks++; if (rf_wr_enable !== mWe || (mWe && (rf_rd !== mRd || rf_write_data !== mData))) begin
        errors++; $display("[TB] FAIL prio_write cyc %0d got we=%b rd=%0d data=%h want we=%b rd=%0d data=%h", cyc, rf_wr_enable, rf_rd, rf_write_data, mWe, mRd, mData);
      end
    end
    checks++; if (stallCnt != 1 || firstStall != 5) begin
      errors++; $display("[TB] FAIL prio_starve got stalls=%0d first=%0d want stalls=1 first=5", stallCnt, firstStall);
    end
    idleInputs();
  endtask

  task automatic test_full_fifo();
    int         idx;
    logic       accepted;
    logic [4:0] got[$];
    doReset();
    idx = 0;
    wb_wr_enable = 1; wb_rd = 3;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (!mStall) begin
        wb_wr_enable = (cyc < 20);
        wb_write_data = 32'(cyc);
      end
      mc_result_valid = (idx < 3);
      mc_result_rd = 5'(11 + idx);
      mc_result_data = 32'hC000 + 32'(idx);
      #1;
      evalComb();
      if (cyc == 2) begin
        checks++; if (mc_result_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got %b want 0", mc_result_ready); end
      end
      checks++; if (mc_result_ready !== mReady) begin errors++; $display("[TB] FAIL full_ready_model cyc %0d got %b want %b", cyc, mc_result_ready, mReady); end
      accepted = mc_result_valid && mReady;
      commitEdge();
      tick();
      if (accepted) idx++;
      if (rf_wr_enable === 1'b1 && rf_rd !== 5'd3) got.push_back(rf_rd);
    end
    checks++; if (got.size() != 3) begin
      errors++; $display("[TB] FAIL full_count got %0d want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (got[k] !== 5'(11 + k)) begin errors++; $display("[TB] FAIL full_order idx %0d got %0d want %0d", k, got[k], 11 + k); end
      end
    end
    idleInputs();
  endtask

  task automatic test_set_clear();
    doReset();
    mc_issue_valid = 1; mc_issue_rd = 9;
    stepModel();
    checks++; if (busy_mask !== 32'h200) begin errors++; $display("[TB] FAIL sc_set got %h want 00000200", busy_mask); end
    mc_issue_valid = 0;
    mc_result_valid = 1; mc_result_rd = 9; mc_result_data = 32'h99;
    stepModel();
    mc_result_valid = 0;
    mc_issue_valid = 1; mc_issue_rd = 9;
    stepModel();
    mc_issue_valid = 0;
    checks++; if (busy_mask !== 32'h200 || rf_wr_enable !== 1'b1 || rf_rd !== 5'd9) begin
      errors++; $display("[TB] FAIL sc_setwins got busy=%h we=%b rd=%0d want busy=00000200 we=1 rd=9", busy_mask, rf_wr_enable, rf_rd);
    end
  endtask

  task automatic test_x0();
    int weSeen;
    doReset();
    weSeen = 0;
    mc_result_valid = 1; mc_result_rd = 0; mc_result_data = 32'h77;
    stepModel();
    mc_result_valid = 0;
    wb_wr_enable = 1; wb_rd = 0; wb_write_data = 32'h5;
    #1;
    evalComb();
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL x0_stall got %b want 0", pipe_stall); end
    commitEdge();
    tick();
    if (rf_wr_enable !== 1'b0) weSeen++;
    wb_wr_enable = 0;
    stepModel(); if (rf_wr_enable !== 1'b0) weSeen++;
    stepModel(); if (rf_wr_enable !== 1'b0) weSeen++;
    checks++; if (weSeen != 0) begin errors++; $display("[TB] FAIL x0_write got %0d strobes want 0", weSeen); end
    mc_result_valid = 1; mc_result_rd = 4; mc_result_data = 32'h44;
    stepModel();
    mc_result_valid = 0;
    stepModel();
    checks++; if (rf_wr_enable !== 1'b1 || rf_rd !== 5'd4 || rf_write_data !== 32'h44) begin
      errors++; $display("[TB] FAIL x0_drained got we=%b rd=%0d data=%h want we=1 rd=4 data=44", rf_wr_enable, rf_rd, rf_write_data);
    end
  endtask

  task automatic test_random();
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!mStall) begin
        wb_wr_enable = ($urandom_range(0, 9) < 7);
        wb_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wb_write_data = $urandom;
      end
      mc_issue_valid = ($urandom_range(0, 3) == 0);
      mc_issue_rd = 5'($urandom_range(0, 31));
      mc_result_valid = ($urandom_range(0, 9) < 4);
      mc_result_rd = 5'($urandom_range(0, 31));
      mc_result_data = $urandom;
      #1;
      evalComb();
      checks++; if (pipe_stall !== mStall || mc_result_ready !== mReady) begin
        errors++; $display("[TB] FAIL rand_comb cyc %0d got stall=%b ready=%b want stall=%b ready=%b", cyc, pipe_stall, mc_result_ready, mStall, mReady);
      end
      commitEdge();
      tick();
      checks++; if (rf_wr_enable !== mWe || busy_mask !== mBusy || (mWe && (rf_rd !== mRd || rf_write_data !== mData))) begin
        errors++; $display("[TB] FAIL rand_reg cyc %0d got we=%b rd=%0d data=%h busy=%h want we=%b rd=%0d data=%h busy=%h",
                          cyc, rf_wr_enable, rf_rd, rf_write_data, busy_mask, mWe, mRd, mData, mBusy);
      end
    end
    idleInputs();
  endtask

  initial begin
    modelReset();
    test_reset();
    test_scoreboard();
    test_priority();
    test_full_fifo();
    test_set_clear();
    test_x0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
